// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: holds one decoded instruction, forwards operands from MEM/WB,
// inserts load-use bubbles, stalls on downstream backpressure and squashes on flush.
module id_ex_stage #(
  parameter int DATA_WIDTH  = 32,
  parameter int ALU_OP_BITS = 4,
  parameter int REG_BITS    = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   id_valid,
  output logic                   id_ready,
  input  logic [ALU_OP_BITS-1:0] id_alu_op,
  input  logic [REG_BITS-1:0]    id_rs,
  input  logic [REG_BITS-1:0]    id_rt,
  input  logic [REG_BITS-1:0]    id_rd,
  input  logic [DATA_WIDTH-1:0]  id_rs_data,
  input  logic [DATA_WIDTH-1:0]  id_rt_data,
  input  logic [DATA_WIDTH-1:0]  id_imm,
  input  logic                   id_alu_src,
  input  logic                   id_reg_write,
  input  logic                   id_mem_read,
  input  logic                   mem_reg_write,
  input  logic [REG_BITS-1:0]    mem_rd,
  input  logic [DATA_WIDTH-1:0]  mem_result,
  input  logic                   wb_reg_write,
  input  logic [REG_BITS-1:0]    wb_rd,
  input  logic [DATA_WIDTH-1:0]  wb_result,
  input  logic                   flush,
  input  logic                   ex_ready,
  output logic                   ex_valid,
  output logic [ALU_OP_BITS-1:0] ex_alu_op,
  output logic [DATA_WIDTH-1:0]  ex_data1,
  output logic [DATA_WIDTH-1:0]  ex_data2,
  output logic [DATA_WIDTH-1:0]  ex_store_data,
  output logic [REG_BITS-1:0]    ex_rd,
  output logic                   ex_reg_write,
  output logic                   ex_mem_read,
  output logic [31:0]            stall_count
);

  logic [REG_BITS-1:0]   ex_rs, ex_rt;
  logic [DATA_WIDTH-1:0] rs_val, rt_val, imm_val;
  logic                  alu_src;
  logic                  slot_free, hazard, load_en;
  logic [DATA_WIDTH-1:0] fwd_rs, fwd_rt;

  // Value captured into the slot: r0 is hardwired, a same-cycle WB write wins over the given value.
  function automatic logic [DATA_WIDTH-1:0] capture(
    input logic [REG_BITS-1:0]   r,
    input logic [DATA_WIDTH-1:0] fallback,
    input logic                  wb_we,
    input logic [REG_BITS-1:0]   wb_r,
    input logic [DATA_WIDTH-1:0] wb_val
  );
    if (r == '0)
      return '0;
    else if (wb_we && wb_r == r)
      return wb_val;
    else
      return fallback;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] forward(
    input logic [REG_BITS-1:0]   r,
    input logic [DATA_WIDTH-1:0] held,
    input logic                  mem_we,
    input logic [REG_BITS-1:0]   mem_r,
    input logic [DATA_WIDTH-1:0] mem_val,
    input logic                  wb_we,
    input logic [REG_BITS-1:0]   wb_r,
    input logic [DATA_WIDTH-1:0] wb_val
  );
    if (r == '0)
      return '0;
    else if (mem_we && mem_r == r)
      return mem_val;
    else if (wb_we && wb_r == r)
      return wb_val;
    else
      return held;
  endfunction

  always_comb begin
    slot_free = !ex_valid || ex_ready;
    hazard    = ex_valid && ex_mem_read && (ex_rd != '0) &&
                ((id_rs == ex_rd) || (id_rt == ex_rd));
    id_ready  = flush || (slot_free && !hazard);
    load_en   = slot_free && id_valid && !hazard;
  end

  always_comb begin
    fwd_rs        = forward(ex_rs, rs_val, mem_reg_write, mem_rd, mem_result,
                            wb_reg_write, wb_rd, wb_result);
    fwd_rt        = forward(ex_rt, rt_val, mem_reg_write, mem_rd, mem_result,
                            wb_reg_write, wb_rd, wb_result);
    ex_data1      = fwd_rs;
    ex_data2      = alu_src ? imm_val : fwd_rt;
    ex_store_data = fwd_rt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid     <= 1'b0;
      ex_alu_op    <= '0;
      ex_rs        <= '0;
      ex_rt        <= '0;
      ex_rd        <= '0;
      rs_val       <= '0;
      rt_val       <= '0;
      imm_val      <= '0;
      alu_src      <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      stall_count  <= '0;
    end else begin
      if (id_valid && !id_ready && !flush && stall_count != 32'hFFFF_FFFF)
        stall_count <= stall_count + 32'd1;

      if (flush) begin
        ex_valid <= 1'b0;
      end else if (load_en) begin
        ex_valid     <= 1'b1;
        ex_alu_op    <= id_alu_op;
        ex_rs        <= id_rs;
        ex_rt        <= id_rt;
        ex_rd        <= id_rd;
        rs_val       <= capture(id_rs, id_rs_data, wb_reg_write, wb_rd, wb_result);
        rt_val       <= capture(id_rt, id_rt_data, wb_reg_write, wb_rd, wb_result);
        imm_val      <= id_imm;
        alu_src      <= id_alu_src;
        ex_reg_write <= id_reg_write;
        ex_mem_read  <= id_mem_read;
      end else if (slot_free) begin
        ex_valid <= 1'b0;
      end else begin
        // Held instruction would miss a WB write that retires while it waits, so refresh it here.
        rs_val <= capture(ex_rs, rs_val, wb_reg_write, wb_rd, wb_result);
        rt_val <= capture(ex_rt, rt_val, wb_reg_write, wb_rd, wb_result);
      end
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus randomized traffic
// compared against an instruction-level reference model.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid, id_ready;
  logic [3:0]  id_alu_op;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic        id_alu_src, id_reg_write, id_mem_read;
  logic        mem_reg_write;
  logic [4:0]  mem_rd;
  logic [31:0] mem_result;
  logic        wb_reg_write;
  logic [4:0]  wb_rd;
  logic [31:0] wb_result;
  logic        flush, ex_ready, ex_valid;
  logic [3:0]  ex_alu_op;
  logic [31:0] ex_data1, ex_data2, ex_store_data;
  logic [4:0]  ex_rd;
  logic        ex_reg_write, ex_mem_read;
  logic [31:0] stall_count;

  int total = 0;
  int bad   = 0;

  id_ex_stage dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_ready(id_ready), .id_alu_op(id_alu_op),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_alu_src(id_alu_src), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .mem_reg_write(mem_reg_write), .mem_rd(mem_rd), .mem_result(mem_result),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_result(wb_result),
    .flush(flush), .ex_ready(ex_ready), .ex_valid(ex_valid), .ex_alu_op(ex_alu_op),
    .ex_data1(ex_data1), .ex_data2(ex_data2), .ex_store_data(ex_store_data),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_id(input logic v, input logic [3:0] op, input logic [4:0] rs,
                          input logic [4:0] rt, input logic [4:0] rd, input logic [31:0] rsd,
                          input logic [31:0] rtd, input logic [31:0] imm, input logic src,
                          input logic rw, input logic mr);
    id_valid = v; id_alu_op = op; id_rs = rs; id_rt = rt; id_rd = rd;
    id_rs_data = rsd; id_rt_data = rtd; id_imm = imm;
    id_alu_src = src; id_reg_write = rw; id_mem_read = mr;
  endtask

  task automatic quiet_bus();
    mem_reg_write = 0; mem_rd = 0; mem_result = 0;
    wb_reg_write = 0; wb_rd = 0; wb_result = 0;
    flush = 0;
  endtask

  task automatic do_reset();
    quiet_bus();
    drive_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    ex_ready = 1;
    reset = 1;
    tick();
    reset = 0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (ex_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid: got %b expected 0", ex_valid); end
    total++; if (id_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_ready: got %b expected 1", id_ready); end
    total++; if (stall_count !== 32'd0) begin bad++; $display("[TB] FAIL reset_stall: got %0d expected 0", stall_count); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive_id(1, 4'd1, 5'd2, 5'd3, 5'd1, 32'd5, 32'd7, 32'd0, 0, 1, 0);
    tick();
    total++; if (ex_valid !== 1'b1 || ex_data1 !== 32'd5 || ex_data2 !== 32'd7 || ex_alu_op !== 4'd1)
      begin bad++; $display("[TB] FAIL b2b_add: got v=%b %0d/%0d op=%0d expected 1 5/7 op=1", ex_valid, ex_data1, ex_data2, ex_alu_op); end
    drive_id(1, 4'd2, 5'd5, 5'd6, 5'd4, 32'd11, 32'd3, 32'd0, 0, 1, 0);
    tick();
    total++; if (ex_valid !== 1'b1 || ex_data1 !== 32'd11 || ex_data2 !== 32'd3 || ex_rd !== 5'd4)
      begin bad++; $display("[TB] FAIL b2b_sub: got v=%b %0d/%0d rd=%0d expected 1 11/3 rd=4", ex_valid, ex_data1, ex_data2, ex_rd); end
    total++; if (stall_count !== 32'd0) begin bad++; $display("[TB] FAIL b2b_stall: got %0d expected 0", stall_count); end
    drive_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    total++; if (ex_valid !== 1'b0) begin bad++; $display("[TB] FAIL b2b_drain: got %b expected 0", ex_valid); end
  endtask

  task automatic test_mem_forward();
    do_reset();
    drive_id(1, 4'd3, 5'd1, 5'd0, 5'd2, 32'd0, 32'd0, 32'd0, 0, 1, 0);
    tick();
    drive_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    mem_reg_write = 1; mem_rd = 5'd1; mem_result = 32'h1234;
    wb_reg_write = 1; wb_rd = 5'd1; wb_result = 32'h9999;
    #1;
    total++; if (ex_data1 !== 32'h1234) begin bad++; $display("[TB] FAIL fwd_mem: got %h expected 1234", ex_data1); end
    mem_reg_write = 0;
    #1;
    total++; if (ex_data1 !== 32'h9999) begin bad++; $display("[TB] FAIL fwd_wb: got %h expected 9999", ex_data1); end
    wb_reg_write = 0;
    #1;
    total++; if (ex_data1 !== 32'h0) begin bad++; $display("[TB] FAIL fwd_none: got %h expected 0", ex_data1); end
  endtask

  task automatic test_load_use();
    do_reset();
    drive_id(1, 4'd0, 5'd2, 5'd0, 5'd1, 32'd0, 32'd0, 32'd4, 1, 1, 1);
    tick();
    drive_id(1, 4'd1, 5'd1, 5'd3, 5'd5, 32'h55, 32'h66, 32'd0, 0, 1, 0);
    #1;
    total++; if (id_ready !== 1'b0) begin bad++; $display("[TB] FAIL lu_ready_low: got %b expected 0", id_ready); end
    tick();
    total++; if (ex_valid !== 1'b0) begin bad++; $display("[TB] FAIL lu_bubble: got %b expected 0", ex_valid); end
    total++; if (id_ready !== 1'b1) begin bad++; $display("[TB] FAIL lu_ready_back: got %b expected 1", id_ready); end
    tick();
    drive_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    total++; if (ex_valid !== 1'b1 || ex_rd !== 5'd5 || ex_data1 !== 32'h55 || ex_data2 !== 32'h66)
      begin bad++; $display("[TB] FAIL lu_issue: got v=%b rd=%0d %h/%h expected 1 rd=5 55/66", ex_valid, ex_rd, ex_data1, ex_data2); end
    total++; if (stall_count !== 32'd1) begin bad++; $display("[TB] FAIL lu_stall: got %0d expected 1", stall_count); end
  endtask

  task automatic test_backpressure();
    do_reset();
    drive_id(1, 4'd1, 5'd2, 5'd0, 5'd3, 32'h10, 32'd0, 32'd0, 0, 1, 0);
    tick();
    drive_id(1, 4'd2, 5'd4, 5'd5, 5'd6, 32'h1, 32'h2, 32'd0, 0, 1, 0);
    ex_ready = 0;
    wb_reg_write = 1; wb_rd = 5'd2; wb_result = 32'hAB;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (id_ready !== 1'b0) begin bad++; $display("[TB] FAIL bp_ready%0d: got %b expected 0", i, id_ready); end
      tick();
      total++; if (ex_valid !== 1'b1) begin bad++; $display("[TB] FAIL bp_valid%0d: got %b expected 1", i, ex_valid); end
    end
    total++; if (stall_count !== 32'd3) begin bad++; $display("[TB] FAIL bp_stall: got %0d expected 3", stall_count); end
    wb_reg_write = 0; ex_ready = 1;
    drive_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    total++; if (ex_data1 !== 32'hAB) begin bad++; $display("[TB] FAIL bp_refresh: got %h expected ab", ex_data1); end
  endtask

  task automatic test_flush();
    do_reset();
    drive_id(1, 4'd1, 5'd1, 5'd2, 5'd3, 32'd1, 32'd2, 32'd0, 0, 1, 0);
    tick();
    drive_id(1, 4'd2, 5'd4, 5'd5, 5'd6, 32'd3, 32'd4, 32'd0, 0, 1, 0);
    ex_ready = 0; flush = 1;
    #1;
    total++; if (id_ready !== 1'b1) begin bad++; $display("[TB] FAIL flush_ready: got %b expected 1", id_ready); end
    tick();
    flush = 0;
    drive_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    total++; if (ex_valid !== 1'b0) begin bad++; $display("[TB] FAIL flush_valid: got %b expected 0", ex_valid); end
    total++; if (stall_count !== 32'd0) begin bad++; $display("[TB] FAIL flush_stall: got %0d expected 0", stall_count); end
  endtask

  task automatic test_reg_zero();
    do_reset();
    drive_id(1, 4'd1, 5'd0, 5'd0, 5'd7, 32'hFFFF, 32'h77, 32'd0, 0, 1, 0);
    mem_reg_write = 1; mem_rd = 5'd0; mem_result = 32'hDEAD;
    wb_reg_write = 1; wb_rd = 5'd0; wb_result = 32'hBEEF;
    tick();
    total++; if (ex_data1 !== 32'd0 || ex_store_data !== 32'd0)
      begin bad++; $display("[TB] FAIL r0: got %h/%h expected 0/0", ex_data1, ex_store_data); end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    drive_id(1, 4'd5, 5'd1, 5'd2, 5'd3, 32'd9, 32'd8, 32'd0, 0, 1, 1);
    tick();
    drive_id(1, 4'd6, 5'd4, 5'd5, 5'd6, 32'd1, 32'd1, 32'd0, 0, 1, 0);
    ex_ready = 0;
    tick();
    tick();
    total++; if (stall_count !== 32'd2) begin bad++; $display("[TB] FAIL rms_pre: got %0d expected 2", stall_count); end
    reset = 1;
    tick();
    reset = 0;
    #1;
    total++; if (ex_valid !== 1'b0 || id_ready !== 1'b1 || stall_count !== 32'd0)
      begin bad++; $display("[TB] FAIL rms_post: got v=%b r=%b s=%0d expected 0 1 0", ex_valid, id_ready, stall_count); end
    total++; if (ex_alu_op !== 4'd0 || ex_rd !== 5'd0 || ex_data1 !== 32'd0 || ex_reg_write !== 1'b0 || ex_mem_read !== 1'b0)
      begin bad++; $display("[TB] FAIL rms_fields: got op=%0d rd=%0d d1=%h rw=%b mr=%b expected all 0", ex_alu_op, ex_rd, ex_data1, ex_reg_write, ex_mem_read); end
  endtask

  // Reference model: the instruction sitting in EX, with the architectural value of each source
  // register as it was last known (register file read, updated by any WB retirement since).
  typedef struct {
    logic        valid;
    logic [3:0]  op;
    logic [4:0]  rs, rt, rd;
    logic [31:0] rs_v, rt_v, imm;
    logic        src, rw, mr;
  } instr_t;

  function automatic logic [31:0] latest(input logic [4:0] r, input logic [31:0] known);
    if (r == 0) return 0;
    if (wb_reg_write && wb_rd == r) return wb_result;
    return known;
  endfunction

  function automatic logic [31:0] operand(input logic [4:0] r, input logic [31:0] known);
    if (r == 0) return 0;
    if (mem_reg_write && mem_rd == r) return mem_result;
    return latest(r, known);
  endfunction

  task automatic test_random();
    instr_t m;
    logic [31:0] m_stall;
    logic haz, exp_ready, exp_d2;
    logic [31:0] e1, e2, es;
    do_reset();
    m = '{valid: 0, op: 0, rs: 0, rt: 0, rd: 0, rs_v: 0, rt_v: 0, imm: 0, src: 0, rw: 0, mr: 0};
    m_stall = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      drive_id($urandom_range(0, 3) != 0, 4'($urandom), 5'($urandom_range(0, 3)),
               5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), $urandom, $urandom,
               $urandom, 1'($urandom), 1'($urandom), $urandom_range(0, 2) == 0);
      mem_reg_write = 1'($urandom); mem_rd = 5'($urandom_range(0, 3)); mem_result = $urandom;
      wb_reg_write = 1'($urandom); wb_rd = 5'($urandom_range(0, 3)); wb_result = $urandom;
      flush = $urandom_range(0, 9) == 0;
      ex_ready = $urandom_range(0, 3) != 0;
      #1;
      haz = m.valid && m.mr && m.rd != 0 && (id_rs == m.rd || id_rt == m.rd);
      exp_ready = flush || ((!m.valid || ex_ready) && !haz);
      total++; if (id_ready !== exp_ready) begin bad++; $display("[TB] FAIL rnd_ready@%0d: got %b expected %b", cyc, id_ready, exp_ready); end
      total++; if (ex_valid !== m.valid) begin bad++; $display("[TB] FAIL rnd_valid@%0d: got %b expected %b", cyc, ex_valid, m.valid); end
      total++; if (stall_count !== m_stall) begin bad++; $display("[TB] FAIL rnd_stall@%0d: got %0d expected %0d", cyc, stall_count, m_stall); end
      if (m.valid) begin
        e1 = operand(m.rs, m.rs_v);
        es = operand(m.rt, m.rt_v);
        e2 = m.src ? m.imm : es;
        total++;
        if (ex_data1 !== e1 || ex_data2 !== e2 || ex_store_data !== es || ex_alu_op !== m.op ||
            ex_rd !== m.rd || ex_reg_write !== m.rw || ex_mem_read !== m.mr)
          begin bad++; $display("[TB] FAIL rnd_fields@%0d: got %h/%h/%h op=%0d rd=%0d rw=%b mr=%b expected %h/%h/%h op=%0d rd=%0d rw=%b mr=%b",
                                cyc, ex_data1, ex_data2, ex_store_data, ex_alu_op, ex_rd, ex_reg_write, ex_mem_read,
                                e1, e2, es, m.op, m.rd, m.rw, m.mr); end
      end
      if (id_valid && !exp_ready && !flush && m_stall != 32'hFFFF_FFFF) m_stall++;
      exp_d2 = !m.valid || ex_ready;
      if (flush) m.valid = 0;
      else if (exp_d2 && id_valid && !haz)
        m = '{valid: 1, op: id_alu_op, rs: id_rs, rt: id_rt, rd: id_rd,
              rs_v: latest(id_rs, id_rs_data), rt_v: latest(id_rt, id_rt_data),
              imm: id_imm, src: id_alu_src, rw: id_reg_write, mr: id_mem_read};
      else if (exp_d2) m.valid = 0;
      else begin
        m.rs_v = latest(m.rs, m.rs_v);
        m.rt_v = latest(m.rt, m.rt_v);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_mem_forward();
    test_load_use();
    test_backpressure();
    test_flush();
    test_reg_zero();
    test_reset_mid_stall();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode-to-execute pipeline stage feeding the `alu` block. Holds one decoded instruction, presents its operation and operands to the ALU, resolves operand forwarding from the MEM and WB stages, detects load-use hazards and inserts bubbles. Stalls on downstream backpressure and squashes on branch flush.

## Interface
- DATA_WIDTH, 32, operand width; matches `DATA_WIDTH.
- ALU_OP_BITS, 4, ALU opcode width; matches `ALU_OP_BITS.
- REG_BITS, 5, register address width.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  reset, synchronous and active-high.
- id_valid  in  1  decode presents an instruction.
- id_ready  out  1  stage accepts the decode instruction this cycle.
- id_alu_op  in  ALU_OP_BITS  ALU operation.
- id_rs, id_rt, id_rd  in  REG_BITS  source and destination register numbers.
- id_rs_data, id_rt_data  in  DATA_WIDTH  register file read values.
- id_imm  in  DATA_WIDTH  extended immediate.
- id_alu_src  in  1  1 selects id_imm as data2.
- id_reg_write, id_mem_read  in  1  writes rd / is a load.
- mem_reg_write  in  1; mem_rd  in  REG_BITS; mem_result  in  DATA_WIDTH  MEM-stage forward source.
- wb_reg_write  in  1; wb_rd  in  REG_BITS; wb_result  in  DATA_WIDTH  WB-stage forward source.
- flush  in  1  branch redirect; squash the held and incoming instruction.
- ex_ready  in  1  downstream accepts the held instruction.
- ex_valid  out  1  held instruction valid.
- ex_alu_op  out  ALU_OP_BITS; ex_data1, ex_data2  out  DATA_WIDTH  to ALU alu_op/data1/data2.
- ex_store_data  out  DATA_WIDTH  forwarded rt value.
- ex_rd  out  REG_BITS; ex_reg_write, ex_mem_read  out  1  control passed downstream.
- stall_count  out  32  cycles decode was refused for a hazard or backpressure.

## Operation
- One-entry register. The slot frees when `!ex_valid || ex_ready`.
- Hazard: ex_valid && ex_mem_read && ex_rd != 0 && (id_rs == ex_rd || id_rt == ex_rd). rt is always checked, regardless of id_alu_src.
- id_ready = flush || (slot frees && !hazard). This is combinational.
- Per-edge priority: reset > flush > load > bubble > hold.
  - reset: every output register goes to 0, including ex_valid and stall_count.
  - flush: ex_valid <= 0. The incoming id instruction is consumed and discarded.
  - load (slot frees, id_valid, !hazard): capture all id_* fields and set ex_valid <= 1.
  - bubble (slot frees, and !id_valid or hazard): ex_valid <= 0. Data fields are don't-care.
  - hold: all fields are kept. Held rs/rt data is refreshed from the WB source (see capture bypass).
- Capture bypass, applied on load and on hold for the held rs/rt data:
  - Register 0 is always captured as 0.
  - Otherwise, if wb_reg_write && wb_rd == reg, capture wb_result.
  - Otherwise keep the register-file value (load) or the held value (hold).
- Output forwarding, combinational, for each of rs and rt:
  - If reg == 0, the value is 0.
  - Else if mem_reg_write && mem_rd == reg, the value is mem_result.
  - Else if wb_reg_write && wb_rd == reg, the value is wb_result.
  - Else the held value.
  - MEM beats WB.
- ex_data1 = forwarded rs. ex_data2 = ex_alu_src ? held imm : forwarded rt. ex_store_data = forwarded rt.
- stall_count increments when id_valid && !id_ready && !flush. It saturates at 0xFFFFFFFF.

## Timing
- Latency: an instruction accepted at edge N appears at ex_valid after edge N; the ALU result is valid in the same cycle.
- A load-use pair costs exactly one bubble cycle when ex_ready = 1.
- Combinational paths:
  - id_ready from ex_ready, flush and the id_rs/id_rt comparators.
  - ex_data1, ex_data2 and ex_store_data from the mem_* and wb_* buses.
- flush and ex_ready together: flush wins.
- Reset mid-stall: the next cycle has ex_valid = 0, id_ready = 1 and stall_count = 0.
- While ex_valid = 0, outputs other than ex_valid carry no meaning; the bench ignores them.

## Test plan
- Back-to-back independent: ADD r1=r2+r3 (r2=5, r3=7), then SUB r4=r5-r6, with ex_ready=1 -> ex_valid high two consecutive cycles; ex_data1/data2 = 5/7 then the r5/r6 values; stall_count = 0.
- MEM forward: held rs=r1 with id_rs_data=0, mem_reg_write=1, mem_rd=1, mem_result=0x1234, plus WB also writing r1=0x9999 -> ex_data1 = 0x1234.
- Load-use: LW r1 held (ex_mem_read=1, ex_rd=1), id_rs=1 -> id_ready=0 for one cycle, one bubble (ex_valid=0), then the instruction loads; stall_count = 1.
- Backpressure: ex_ready=0 for 3 cycles while wb writes r2=0xAB (held rs=r2) -> ex_valid stays, id_ready=0, stall_count = 3; after ex_ready=1, ex_data1 = 0xAB with no forward sources active.
- Flush: held valid and id_valid=1 with flush=1 -> next cycle ex_valid=0, id_ready was 1, stall_count unchanged.
- Register 0 and reset: id_rs=0, id_rs_data=0xFFFF, mem_rd=0 with mem_reg_write=1 -> ex_data1 = 0. Assert reset during a stall -> all outputs 0 the next cycle.
